usb_buffer_arbiter: RTL and testbench



---
 rtl/usb_buffer_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_usb_buffer_arbiter.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/usb_buffer_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : usb_buffer_arbiter
// Purpose  : Owns the 256-word USB data buffer RAM and passes ownership between
//            the USB module and the core. The USB side fills the buffer and
//            signals a packet; the core then owns it until it writes the USB
//            control register, after which a one-cycle dead period hands it
//            back. One early packet notification can be queued.
// Optional : define USB_BUFFER_TIMEOUT_EN to add a watchdog that revokes core
//            ownership after TIMEOUT_CYCLES clk24 cycles.
// Ports    : clk24/reset           - clock, synchronous active-high reset
//            usb_*                 - USB packet notify, control word, writes
//            core_*                - core buffer access (word addr, data, strb)
//            ctrl_wstrb/ctrl_wdata - core write to the USB control register
//            buf_*                 - RAM write port (addr also used for reads)
//            core_owns             - core currently owns the buffer
//            usb_control           - latched control word
//            core_fault            - sticky: core wrote while not owner
//            packet_dropped        - sticky: packet lost with queue full
//            timeout               - one-cycle pulse on watchdog revocation
// Revision : 1.0 - initial release
// ============================================================================
module usb_buffer_arbiter #(
    parameter int ADDR_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 2400000
) (
    input  logic                  clk24,
    input  logic                  reset,
    input  logic                  usb_got_packet,
    input  logic [15:0]           usb_control_in,
    input  logic [ADDR_WIDTH-1:0] usb_addr,
    input  logic [31:0]           usb_wdata,
    input  logic                  usb_we,
    input  logic                  core_sel,
    input  logic [ADDR_WIDTH-1:0] core_addr,
    input  logic [31:0]           core_wdata,
    input  logic [3:0]            core_wstrb,
    input  logic [1:0]            ctrl_wstrb,
    input  logic [15:0]           ctrl_wdata,
    output logic [ADDR_WIDTH-1:0] buf_addr,
    output logic [31:0]           buf_wdata,
    output logic [3:0]            buf_wstrb,
    output logic                  core_owns,
    output logic [15:0]           usb_control,
    output logic                  core_fault,
    output logic                  packet_dropped,
    output logic                  timeout
);

    typedef enum logic [1:0] {
        USB_OWN  = 2'd0,
        CORE_OWN = 2'd1,
        RELEASE  = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic        r_core_owns;
    logic [15:0] r_usb_control;
    logic [15:0] r_shadow;
    logic        r_pending;
    logic        r_core_fault;
    logic        r_packet_dropped;
    logic        r_timeout;

    logic        w_ctrl_write;
    logic        w_core_write;
    logic        w_wd_expired;

    assign w_ctrl_write = |ctrl_wstrb;
    assign w_core_write = core_sel && (|core_wstrb);

`ifdef USB_BUFFER_TIMEOUT_EN
    localparam logic [23:0] c_WD_LAST = 24'(TIMEOUT_CYCLES - 1);

    logic [23:0] r_wd_count;

    // Held at zero outside CORE_OWN, so every ownership period starts at 0.
    always_ff @(posedge clk24) begin
        if (reset) begin
            r_wd_count <= '0;
        end else if (r_state != CORE_OWN) begin
            r_wd_count <= '0;
        end else begin
            r_wd_count <= r_wd_count + 24'd1;
        end
    end

    assign w_wd_expired = (r_state == CORE_OWN) && (r_wd_count == c_WD_LAST);
`else
    logic [31:0] w_unused_timeout_cfg;
    assign w_unused_timeout_cfg = 32'(TIMEOUT_CYCLES);
    assign w_wd_expired         = 1'b0;
`endif

    // Next state and RAM port steering.
    always_comb begin
        w_next_state = r_state;
        buf_addr     = usb_addr;
        buf_wdata    = usb_wdata;
        buf_wstrb    = 4'b0000;
        case (r_state)
            USB_OWN: begin
                buf_wstrb = {4{usb_we}};
                if (r_pending || usb_got_packet) begin
                    w_next_state = CORE_OWN;
                end
            end
            CORE_OWN: begin
                buf_addr  = core_addr;
                buf_wdata = core_wdata;
                buf_wstrb = core_sel ? core_wstrb : 4'b0000;
                if (w_ctrl_write || w_wd_expired) begin
                    w_next_state = RELEASE;
                end
            end
            RELEASE: begin
                w_next_state = USB_OWN;
            end
            default: begin
                w_next_state = USB_OWN;
            end
        endcase
    end

    always_ff @(posedge clk24) begin
        if (reset) begin
            r_state          <= USB_OWN;
            r_core_owns      <= 1'b0;
            r_usb_control    <= 16'h0000;
            r_shadow         <= 16'h0000;
            r_pending        <= 1'b0;
            r_core_fault     <= 1'b0;
            r_packet_dropped <= 1'b0;
            r_timeout        <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_core_owns <= (w_next_state == CORE_OWN);
            // A control write in the expiry cycle takes precedence.
            r_timeout   <= w_wd_expired && !w_ctrl_write;

            case (r_state)
                USB_OWN: begin
                    if (w_core_write) begin
                        r_core_fault <= 1'b1;
                    end
                    // The queued packet is older, so it is served first; a
                    // fresh packet arriving in the same cycle refills the slot.
                    if (r_pending) begin
                        r_usb_control <= r_shadow;
                        if (usb_got_packet) begin
                            r_shadow <= usb_control_in;
                        end else begin
                            r_pending <= 1'b0;
                        end
                    end else if (usb_got_packet) begin
                        r_usb_control <= usb_control_in;
                    end
                end
                CORE_OWN: begin
                    if (ctrl_wstrb[0]) begin
                        r_usb_control[7:0] <= ctrl_wdata[7:0];
                    end
                    if (ctrl_wstrb[1]) begin
                        r_usb_control[15:8] <= ctrl_wdata[15:8];
                    end
                end
                default: begin
                end
            endcase

            // Early packets while the core holds (or is releasing) the buffer.
            if (usb_got_packet && (r_state != USB_OWN)) begin
                if (!r_pending) begin
                    r_shadow  <= usb_control_in;
                    r_pending <= 1'b1;
                end else begin
                    r_packet_dropped <= 1'b1;
                end
            end
        end
    end

    assign core_owns      = r_core_owns;
    assign usb_control    = r_usb_control;
    assign core_fault     = r_core_fault;
    assign packet_dropped = r_packet_dropped;
    assign timeout        = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_usb_buffer_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_usb_buffer_arbiter
// Purpose  : Self-checking bench for usb_buffer_arbiter. A table of per-cycle
//            input/expected-output records walks the ownership handoff, then
//            hand-written sequences cover reset mid-ownership and long holds
//            (watchdog expiry when USB_BUFFER_TIMEOUT_EN is defined).
// Revision : 1.0 - initial release
// ============================================================================
module tb_usb_buffer_arbiter;

    logic        clk24 = 1'b0;
    logic        reset;
    logic        usb_got_packet;
    logic [15:0] usb_control_in;
    logic [7:0]  usb_addr;
    logic [31:0] usb_wdata;
    logic        usb_we;
    logic        core_sel;
    logic [7:0]  core_addr;
    logic [31:0] core_wdata;
    logic [3:0]  core_wstrb;
    logic [1:0]  ctrl_wstrb;
    logic [15:0] ctrl_wdata;
    logic [7:0]  buf_addr;
    logic [31:0] buf_wdata;
    logic [3:0]  buf_wstrb;
    logic        core_owns;
    logic [15:0] usb_control;
    logic        core_fault;
    logic        packet_dropped;
    logic        timeout;

    int errors = 0;
    int checks = 0;

    usb_buffer_arbiter #(
        .ADDR_WIDTH     (8),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk24          (clk24),
        .reset          (reset),
        .usb_got_packet (usb_got_packet),
        .usb_control_in (usb_control_in),
        .usb_addr       (usb_addr),
        .usb_wdata      (usb_wdata),
        .usb_we         (usb_we),
        .core_sel       (core_sel),
        .core_addr      (core_addr),
        .core_wdata     (core_wdata),
        .core_wstrb     (core_wstrb),
        .ctrl_wstrb     (ctrl_wstrb),
        .ctrl_wdata     (ctrl_wdata),
        .buf_addr       (buf_addr),
        .buf_wdata      (buf_wdata),
        .buf_wstrb      (buf_wstrb),
        .core_owns      (core_owns),
        .usb_control    (usb_control),
        .core_fault     (core_fault),
        .packet_dropped (packet_dropped),
        .timeout        (timeout)
    );

    always #5 clk24 = ~clk24;

    typedef struct {
        logic        got;
        logic [15:0] cin;
        logic [7:0]  ua;
        logic [31:0] uwd;
        logic        uwe;
        logic        cs;
        logic [7:0]  ca;
        logic [31:0] cwd;
        logic [3:0]  cws;
        logic [1:0]  tws;
        logic [15:0] twd;
        logic [7:0]  e_addr;
        logic [31:0] e_wdata;
        logic [3:0]  e_wstrb;
        logic        e_owns;
        logic [15:0] e_ctrl;
        logic        e_fault;
        logic        e_drop;
    } vec_t;

    localparam int NV = 19;
    vec_t vecs[NV];

    function automatic vec_t mk(
        input logic got, input logic [15:0] cin, input logic [7:0] ua,
        input logic [31:0] uwd, input logic uwe, input logic cs,
        input logic [7:0] ca, input logic [31:0] cwd, input logic [3:0] cws,
        input logic [1:0] tws, input logic [15:0] twd,
        input logic [7:0] e_addr, input logic [31:0] e_wdata,
        input logic [3:0] e_wstrb, input logic e_owns, input logic [15:0] e_ctrl,
        input logic e_fault, input logic e_drop);
        vec_t v;
        v.got = got; v.cin = cin; v.ua = ua; v.uwd = uwd; v.uwe = uwe;
        v.cs = cs; v.ca = ca; v.cwd = cwd; v.cws = cws; v.tws = tws; v.twd = twd;
        v.e_addr = e_addr; v.e_wdata = e_wdata; v.e_wstrb = e_wstrb;
        v.e_owns = e_owns; v.e_ctrl = e_ctrl; v.e_fault = e_fault; v.e_drop = e_drop;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        usb_got_packet = 1'b0; usb_control_in = '0; usb_addr = '0; usb_wdata = '0;
        usb_we = 1'b0; core_sel = 1'b0; core_addr = '0; core_wdata = '0;
        core_wstrb = '0; ctrl_wstrb = '0; ctrl_wdata = '0;
    endtask

    // Move to the next falling edge (inputs change here, away from posedge).
    task automatic next_cycle();
        @(negedge clk24);
    endtask

    initial begin
        int first_rel;
        int pulses;

        //        got cin    ua   uwd          we cs ca   cwd          cws   tws   twd      | addr  wdata        wstrb owns ctrl     flt drp
        vecs[0]  = mk(0, 16'h0,   8'h03, 32'h11111111, 1, 0, 8'h00, 32'h0,        4'h0, 2'b00, 16'h0,    8'h03, 32'h11111111, 4'hF, 0, 16'h0000, 0, 0);
        vecs[1]  = mk(1, 16'h0123,8'h04, 32'h22222222, 1, 0, 8'h00, 32'h0,        4'h0, 2'b00, 16'h0,    8'h04, 32'h22222222, 4'hF, 0, 16'h0000, 0, 0);
        vecs[2]  = mk(0, 16'h0,   8'h07, 32'h55555555, 1, 1, 8'h05, 32'hAABBCCDD, 4'h3, 2'b00, 16'h0,    8'h05, 32'hAABBCCDD, 4'h3, 1, 16'h0123, 0, 0);
        vecs[3]  = mk(0, 16'h0,   8'h07, 32'h55555555, 1, 0, 8'h06, 32'hCAFEF00D, 4'hF, 2'b00, 16'h0,    8'h06, 32'hCAFEF00D, 4'h0, 1, 16'h0123, 0, 0);
        vecs[4]  = mk(0, 16'h0,   8'h00, 32'h0,        0, 1, 8'h09, 32'h12345678, 4'hC, 2'b01, 16'h0042, 8'h09, 32'h12345678, 4'hC, 1, 16'h0123, 0, 0);
        vecs[5]  = mk(0, 16'h0,   8'h08, 32'h33333333, 1, 0, 8'h00, 32'h0,        4'h0, 2'b00, 16'h0,    8'h08, 32'h33333333, 4'h0, 0, 16'h0142, 0, 0);
        vecs[6]  = mk(0, 16'h0,   8'h08, 32'h33333333, 1, 0, 8'h00, 32'h0,        4'h0, 2'b00, 16'h0,    8'h08, 32'h33333333, 4'hF, 0, 16'h0142, 0, 0);
        vecs[7]  = mk(0, 16'h0,   8'h01, 32'h66666666, 0, 1, 8'h02, 32'h77777777, 4'hF, 2'b00, 16'h0,    8'h01, 32'h66666666, 4'h0, 0, 16'h0142, 0, 0);
        vecs[8]  = mk(0, 16'h0,   8'h01, 32'h66666666, 0, 0, 8'h00, 32'h0,        4'h0, 2'b00, 16'h0,    8'h01, 32'h66666666, 4'h0, 0, 16'h0142, 1, 0);
        vecs[9]  = mk(1, 16'h00AA,8'h00, 32'h0,        0, 0, 8'h00, 32'h0,        4'h0, 2'b00, 16'h0,    8'h00, 32'h0,        4'h0, 0, 16'h0142, 1, 0);
        vecs[10] = mk(1, 16'h0001,8'h00, 32'h0,        0, 0, 8'h00, 32'h0,        4'h0, 2'b00, 16'h0,    8'h00, 32'h0,        4'h0, 1, 16'h00AA, 1, 0);
        vecs[11] = mk(1, 16'h0002,8'h00, 32'h0,        0, 0, 8'h00, 32'h0,        4'h0, 2'b00, 16'h0,    8'h00, 32'h0,        4'h0, 1, 16'h00AA, 1, 0);
        vecs[12] = mk(0, 16'h0,   8'h00, 32'h0,        0, 0, 8'h00, 32'h0,        4'h0, 2'b10, 16'h5500, 8'h00, 32'h0,        4'h0, 1, 16'h00AA, 1, 1);
        vecs[13] = mk(0, 16'h0,   8'h00, 32'h0,        0, 0, 8'h00, 32'h0,        4'h0, 2'b00, 16'h0,    8'h00, 32'h0,        4'h0, 0, 16'h55AA, 1, 1);
        vecs[14] = mk(0, 16'h0,   8'h10, 32'h44444444, 1, 0, 8'h00, 32'h0,        4'h0, 2'b00, 16'h0,    8'h10, 32'h44444444, 4'hF, 0, 16'h55AA, 1, 1);
        vecs[15] = mk(0, 16'h0,   8'h00, 32'h0,        0, 0, 8'h00, 32'h0,        4'h0, 2'b11, 16'hBEEF, 8'h00, 32'h0,        4'h0, 1, 16'h0001, 1, 1);
        vecs[16] = mk(1, 16'h0777,8'h00, 32'h0,        0, 0, 8'h00, 32'h0,        4'h0, 2'b00, 16'h0,    8'h00, 32'h0,        4'h0, 0, 16'hBEEF, 1, 1);
        vecs[17] = mk(0, 16'h0,   8'h00, 32'h0,        0, 0, 8'h00, 32'h0,        4'h0, 2'b00, 16'h0,    8'h00, 32'h0,        4'h0, 0, 16'hBEEF, 1, 1);
        vecs[18] = mk(0, 16'h0,   8'h00, 32'h0,        0, 0, 8'h00, 32'h0,        4'h0, 2'b00, 16'h0,    8'h00, 32'h0,        4'h0, 1, 16'h0777, 1, 1);

        // Reset
        idle_inputs();
        reset = 1'b1;
        repeat (3) @(posedge clk24);
        next_cycle();
        reset = 1'b0;
        #1;
        chk("reset core_owns",      32'(core_owns),      32'd0);
        chk("reset usb_control",    32'(usb_control),    32'd0);
        chk("reset core_fault",     32'(core_fault),     32'd0);
        chk("reset packet_dropped", 32'(packet_dropped), 32'd0);
        chk("reset timeout",        32'(timeout),        32'd0);

        // Table-driven handoff walk: one row per clock cycle.
        for (int i = 0; i < NV; i++) begin
            usb_got_packet = vecs[i].got; usb_control_in = vecs[i].cin;
            usb_addr = vecs[i].ua; usb_wdata = vecs[i].uwd; usb_we = vecs[i].uwe;
            core_sel = vecs[i].cs; core_addr = vecs[i].ca; core_wdata = vecs[i].cwd;
            core_wstrb = vecs[i].cws; ctrl_wstrb = vecs[i].tws; ctrl_wdata = vecs[i].twd;
            #1;
            chk($sformatf("row%0d buf_addr", i),       32'(buf_addr),       32'(vecs[i].e_addr));
            chk($sformatf("row%0d buf_wdata", i),      buf_wdata,           vecs[i].e_wdata);
            chk($sformatf("row%0d buf_wstrb", i),      32'(buf_wstrb),      32'(vecs[i].e_wstrb));
            chk($sformatf("row%0d core_owns", i),      32'(core_owns),      32'(vecs[i].e_owns));
            chk($sformatf("row%0d usb_control", i),    32'(usb_control),    32'(vecs[i].e_ctrl));
            chk($sformatf("row%0d core_fault", i),     32'(core_fault),     32'(vecs[i].e_fault));
            chk($sformatf("row%0d packet_dropped", i), 32'(packet_dropped), 32'(vecs[i].e_drop));
            chk($sformatf("row%0d timeout", i),        32'(timeout),        32'd0);
            next_cycle();
        end

        // Reset while the core owns the buffer and a packet is queued.
        idle_inputs();
        usb_got_packet = 1'b1; usb_control_in = 16'h0999;
        next_cycle();
        idle_inputs();
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        #1;
        chk("midreset core_owns",      32'(core_owns),      32'd0);
        chk("midreset usb_control",    32'(usb_control),    32'd0);
        chk("midreset core_fault",     32'(core_fault),     32'd0);
        chk("midreset packet_dropped", 32'(packet_dropped), 32'd0);
        next_cycle();
        next_cycle();
        #1;
        chk("midreset pending lost",   32'(core_owns),      32'd0);
        chk("midreset ctrl kept 0",    32'(usb_control),    32'd0);

        // Long hold of ownership.
        next_cycle();
        usb_got_packet = 1'b1; usb_control_in = 16'h0ABC;
        next_cycle();
        idle_inputs();
        first_rel = -1;
        pulses    = 0;
        for (int k = 0; k < 40; k++) begin
            #1;
            if (!core_owns && first_rel < 0) first_rel = k;
            if (timeout) pulses++;
            next_cycle();
        end
        chk("hold usb_control", 32'(usb_control), 32'h0ABC);
`ifdef USB_BUFFER_TIMEOUT_EN
        chk("timeout release cycle", 32'(first_rel), 32'd16);
        chk("timeout pulse count",   32'(pulses),     32'd1);
`else
        chk("no-watchdog release",   32'(first_rel),  32'hFFFFFFFF);
        chk("no-watchdog pulses",    32'(pulses),     32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Absolute time bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
`default_nettype wire
